// File: rtl/cs_resolve_seq.sv
// -----------------------------------------------------------------------------
// cs_resolve_seq
//
// Sequential carry-propagate resolver for the two carry-save rows produced by
// the 8x8 Dadda multiplier tree. A captured pair is summed DIGIT bits per clock,
// least-significant digit first, and only a single carry bit passes from one
// digit to the next. The binary result is held on the output handshake until it
// is consumed. In the same cycle, a new pair can be accepted back-to-back.
//
// Parameters
//   WIDTH      width of each carry-save row and of the result
//   DIGIT      bits resolved per ADD cycle; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_a/in_b hold a valid pair
//   in_ready   block can accept a pair this cycle (combinational)
//   in_a       carry-save row 1
//   in_b       carry-save row 2
//   out_valid  out_sum/out_ovf hold a valid result (registered)
//   out_ready  consumer accepts the result this cycle
//   out_sum    (in_a + in_b) mod 2^WIDTH (registered)
//   out_ovf    carry out of bit WIDTH-1 (registered)
// -----------------------------------------------------------------------------
module cs_resolve_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The rows and the result are kept as arrays of digits. The active digit
    // can then be selected directly by the digit index.
    typedef logic [NDIG-1:0][DIGIT-1:0] digits_t;

    state_t          state_q, state_d;
    digits_t         a_q, a_d;
    digits_t         b_q, b_d;
    digits_t         sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    logic            accept;
    logic [DIGIT:0]  digit_res;

    // in_ready depends only on state and out_ready, so there is no path from
    // in_valid. It is forced low while reset is asserted. In DONE it follows
    // out_ready, which lets a new pair enter on the same edge that the
    // current result leaves.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    // One digit of the ripple: the slice of each row plus the single carry bit
    // from the previous digit. No lookahead spans digit boundaries.
    assign digit_res = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{DIGIT{1'b0}}, carry_q};

    // NOTE: every signal driven here gets its hold value first, so that paths
    // that do not assign it cannot infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end

            ADD: begin
                sum_d[idx_q] = digit_res[DIGIT-1:0];
                carry_d      = digit_res[DIGIT];
                if (idx_q == LAST_IDX) begin
                    // Final digit: the index stays at NDIG-1 instead of wrapping.
                    ovf_d   = digit_res[DIGIT];
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end

            DONE: begin
                // If out_ready is low, hold everything and ignore in_valid.
                // in_ready is low in that case, so accept is also low.
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (accept) begin
                        a_d     = in_a;
                        b_d     = in_b;
                        carry_d = 1'b0;
                        idx_d   = '0;
                        state_d = ADD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: the row and result registers are reset along with the control
    // state, because out_sum must read zero during and after reset. The rows
    // share the same reset for simplicity; they are too small to matter.
    // NOTE: non-blocking assignments are used, so every flop samples the
    // pre-edge values of the other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cs_resolve_seq.sv
// -----------------------------------------------------------------------------
// tb_cs_resolve_seq
//
// Directed bench for cs_resolve_seq. Expected results are pushed to a
// scoreboard queue when a pair is driven. They are popped and compared when
// the DUT presents out_valid. Outputs are sampled 1 time unit after the rising
// edge, and inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_cs_resolve_seq;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int TMO   = 50;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    cs_resolve_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference carry-save reduction of the 8 partial products of a*b down to
    // two rows. The pair sums to a*b but is generally not a trivial split.
    task automatic mult_rows(input logic [7:0] a, input logic [7:0] b,
                             output logic [WIDTH-1:0] r1, output logic [WIDTH-1:0] r2);
        logic [WIDTH-1:0] pp;
        logic [WIDTH-1:0] s;
        r1 = b[0] ? WIDTH'(a) : '0;
        r2 = b[1] ? (WIDTH'(a) << 1) : '0;
        for (int i = 2; i < 8; i++) begin
            pp = b[i] ? (WIDTH'(a) << i) : '0;
            s  = r1 ^ r2 ^ pp;
            r2 = ((r1 & r2) | (r1 & pp) | (r2 & pp)) << 1;
            r1 = s;
        end
    endtask

    // Present a pair and wait for acceptance. Returns 1 time unit after the
    // accepting edge. The expected result goes to the scoreboard unless the
    // operation is about to be aborted.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        int n;
        exp_t e;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < TMO) begin
            tick();
            n++;
        end
        if (n >= TMO) check("accept_timeout", 32'(n), 32'(0));
        tick();
        in_valid = 1'b0;
        if (push) begin
            e.sum = a + b;
            e.ovf = ({1'b0, a} + {1'b0, b}) >> WIDTH;
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < TMO) begin
            tick();
            cycles++;
        end
        if (cycles >= TMO) check("valid_timeout", 32'(cycles), 32'(0));
    endtask

    // Compare the presented result against the scoreboard head, then consume it.
    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(out_sum), 32'(e.sum));
            check({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
        end
    endtask

    task automatic collect(input string tag);
        compare_head(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'(0));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat;
        send(a, b, 1'b1);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(NDIG));
        collect(tag);
    endtask

    initial begin
        int               lat;
        bit               saw_valid;
        logic [7:0]       ma, mb;
        logic [WIDTH-1:0] r1, r2;
        exp_t             e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_sum", 32'(out_sum), 32'(0));
        check("rst_out_ovf", 32'(out_ovf), 32'(0));
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'(1));
        tick();

        // Basic add, a cross-digit carry chain, and overflow with wrap.
        run_op("basic", 16'h1234, 16'h4321);
        run_op("carry_chain", 16'h0FFF, 16'h0001);
        run_op("overflow", 16'hFFFF, 16'h0001);

        // Multiplier rows: the expected product is a*b, not the sum of the rows.
        mult_rows(8'hFF, 8'hFF, r1, r2);
        send(r1, r2, 1'b0);
        e.sum = 16'hFE01;
        e.ovf = 1'b0;
        sb.push_back(e);
        wait_valid(lat);
        collect("mult_ff");

        for (int i = 0; i < 16; i++) begin
            ma = 8'($urandom_range(0, 255));
            mb = 8'($urandom_range(0, 255));
            mult_rows(ma, mb, r1, r2);
            send(r1, r2, 1'b0);
            e.sum = WIDTH'(ma) * WIDTH'(mb);
            e.ovf = 1'b0;
            sb.push_back(e);
            wait_valid(lat);
            collect("mult_rand");
        end

        // Backpressure: hold the result for 3 cycles while a stray pair is offered.
        send(16'h0007, 16'h0008, 1'b1);
        wait_valid(lat);
        in_a     = 16'hAAAA;
        in_b     = 16'h1111;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_out_sum", 32'(out_sum), 32'(16'h000F));
            tick();
        end

        // Back-to-back: consume the result and accept 2+3 on the same edge.
        in_a      = 16'h0002;
        in_b      = 16'h0003;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'(1));
        compare_head("b2b_first");
        e.sum = 16'h0005;
        e.ovf = 1'b0;
        sb.push_back(e);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_valid_drop", 32'(out_valid), 32'(0));
        wait_valid(lat);
        check("b2b_latency", 32'(lat), 32'(NDIG));
        collect("b2b_second");

        // Reset during the second ADD cycle. The operation must be discarded.
        send(16'h1234, 16'h1111, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_sum", 32'(out_sum), 32'(0));
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_out_ovf", 32'(out_ovf), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(0));
        tick();
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 2 * NDIG; i++) begin
            #1;
            if (out_valid) saw_valid = 1'b1;
            tick();
        end
        check("mid_rst_no_valid", 32'(saw_valid), 32'(0));
        run_op("post_rst", 16'h00FF, 16'h0001);

        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
